// File: rtl/button_pulse_gen_if.sv
// Button front-end signal bundle: raw input and repeat enable in, clean strobe/level/count out.
interface button_pulse_gen_if;
    logic       btn_raw;
    logic       repeat_en;
    logic       btn_pulse;
    logic       btn_level;
    logic [7:0] press_cnt;

    // Driver side (stimulus or upstream logic)
    modport master (
        output btn_raw,
        output repeat_en,
        input  btn_pulse,
        input  btn_level,
        input  press_cnt
    );

    // Button conditioner side
    modport slave (
        input  btn_raw,
        input  repeat_en,
        output btn_pulse,
        output btn_level,
        output press_cnt
    );
endinterface

// File: rtl/button_pulse_gen.sv
// button_pulse_gen: synchronise and debounce a raw push button, emit one strobe per press
// plus optional auto-repeat strobes while held, and count accepted presses.
module button_pulse_gen #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    button_pulse_gen_if.slave bus
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

    // The cycle that leaves IDLE/HELD already counts as the first stable sample, so the
    // debounce states finish when db_cnt reaches DEBOUNCE_CYCLES-2.
    localparam logic [DbW-1:0]  DbLast        = DbW'(DEBOUNCE_CYCLES - 2);
    localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPressDb,
        StHeld,
        StRepeat,
        StRelDb
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    state_e                 state_q;
    logic [DbW-1:0]         db_cnt_q;
    logic [RepW-1:0]        rep_cnt_q;
    logic                   pulse_q;
    logic                   level_q;
    logic [7:0]             press_cnt_q;

    // Synchroniser chain, reset to the not-pressed raw level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_raw};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // Debounce / hold / repeat FSM with registered strobe, level and press counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            db_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            pulse_q     <= 1'b0;
            level_q     <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (btn_s) begin
                        state_q  <= StPressDb;
                        db_cnt_q <= '0;
                    end
                end
                StPressDb: begin
                    if (!btn_s) begin
                        state_q  <= StIdle;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DbLast) begin
                        state_q     <= StHeld;
                        db_cnt_q    <= '0;
                        rep_cnt_q   <= '0;
                        pulse_q     <= 1'b1;
                        level_q     <= 1'b1;
                        press_cnt_q <= press_cnt_q + 8'd1;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                StHeld: begin
                    // Release is checked first so it wins over a coincident repeat compare
                    if (!btn_s) begin
                        state_q   <= StRelDb;
                        db_cnt_q  <= '0;
                        rep_cnt_q <= '0;
                    end else if (bus.repeat_en) begin
                        if (rep_cnt_q == RepDelayLast) begin
                            state_q   <= StRepeat;
                            rep_cnt_q <= '0;
                            pulse_q   <= 1'b1;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + 1'b1;
                        end
                    end else begin
                        rep_cnt_q <= '0;
                    end
                end
                StRepeat: begin
                    if (!btn_s) begin
                        state_q   <= StRelDb;
                        db_cnt_q  <= '0;
                        rep_cnt_q <= '0;
                    end else if (!bus.repeat_en) begin
                        state_q   <= StHeld;
                        rep_cnt_q <= '0;
                    end else if (rep_cnt_q == RepPeriodLast) begin
                        rep_cnt_q <= '0;
                        pulse_q   <= 1'b1;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + 1'b1;
                    end
                end
                StRelDb: begin
                    if (btn_s) begin
                        state_q   <= StHeld;
                        db_cnt_q  <= '0;
                        rep_cnt_q <= '0;
                    end else if (db_cnt_q == DbLast) begin
                        state_q  <= StIdle;
                        db_cnt_q <= '0;
                        level_q  <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.btn_pulse = pulse_q;
    assign bus.btn_level = level_q;
    assign bus.press_cnt = press_cnt_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with small debounce/repeat parameters.
module tb_button_pulse_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    button_pulse_gen_if bus ();

    button_pulse_gen #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5),
        .ACTIVE_LOW     (1'b0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;
    int pulses[$];
    logic [7:0] led;

    // Cycle index, advanced on each active edge
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Record the cycle index of every strobe, sampled mid-cycle
    always @(negedge clk) if (rst_n && bus.btn_pulse) pulses.push_back(cyc_n);

    // Light chaser stand-in: rotates one position per strobe, reset by ~rst_n
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) led <= 8'h01;
        else if (bus.btn_pulse) led <= {led[6:0], led[7]};
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        pulses.delete();
    endtask

    task automatic press();
        bus.btn_raw = 1'b1;
        tick(8);
        bus.btn_raw = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        bus.btn_raw   = 1'b0;
        bus.repeat_en = 1'b0;
        rst_n         = 1'b0;
        tick(3);
        n_vec++;
        if (bus.btn_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pulse: got %b, expected 0", bus.btn_pulse);
        end
        n_vec++;
        if (bus.btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL reset_level: got %b, expected 0", bus.btn_level);
        end
        n_vec++;
        if (bus.press_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d, expected 0", bus.press_cnt);
        end
    endtask

    task automatic test_clean_press();
        int c0;
        int got;
        apply_reset();
        c0 = cyc_n;
        bus.btn_raw = 1'b1;
        tick(5);
        n_vec++;
        if (bus.btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL clean_level_early: got %b, expected 0", bus.btn_level);
        end
        tick(1);
        n_vec++;
        if (bus.btn_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL clean_pulse_at_6: got %b, expected 1", bus.btn_pulse);
        end
        n_vec++;
        if (bus.btn_level !== 1'b1) begin
            n_err++;
            $display("FAIL clean_level_at_6: got %b, expected 1", bus.btn_level);
        end
        tick(14);
        n_vec++;
        if (pulses.size() != 1) begin
            n_err++;
            $display("FAIL clean_pulse_count: got %0d, expected 1", pulses.size());
        end
        got = (pulses.size() > 0) ? pulses[0] - c0 : -1;
        n_vec++;
        if (got != 6) begin
            n_err++;
            $display("FAIL clean_latency: got %0d, expected 6", got);
        end
        n_vec++;
        if (bus.press_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL clean_cnt: got %0d, expected 1", bus.press_cnt);
        end
        bus.btn_raw = 1'b0;
        tick(10);
        n_vec++;
        if (bus.btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL clean_level_release: got %b, expected 0", bus.btn_level);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        int level_hi;
        apply_reset();
        pat = 5'b10110;
        level_hi = 0;
        for (int i = 4; i >= 0; i--) begin
            bus.btn_raw = pat[i];
            tick(1);
            if (bus.btn_level) level_hi++;
        end
        bus.btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (bus.btn_level) level_hi++;
        end
        n_vec++;
        if (pulses.size() != 0) begin
            n_err++;
            $display("FAIL bounce_pulses: got %0d, expected 0", pulses.size());
        end
        n_vec++;
        if (level_hi != 0) begin
            n_err++;
            $display("FAIL bounce_level: got %0d high cycles, expected 0", level_hi);
        end
        n_vec++;
        if (bus.press_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL bounce_cnt: got %0d, expected 0", bus.press_cnt);
        end
    endtask

    // Hold with repeat enabled for 'hold' cycles after the raw edge, then release
    task automatic test_repeat(input int hold);
        int c0;
        int c1;
        int exp_q[$];
        int got;
        apply_reset();
        bus.repeat_en = 1'b1;
        c0 = cyc_n;
        bus.btn_raw = 1'b1;
        tick(hold);
        c1 = cyc_n;
        bus.btn_raw = 1'b0;
        tick(5);
        n_vec++;
        if (bus.btn_level !== 1'b1) begin
            n_err++;
            $display("FAIL repeat%0d_level_pre_fall: got %b, expected 1", hold, bus.btn_level);
        end
        tick(1);
        n_vec++;
        if (bus.btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL repeat%0d_level_fall: got %b, expected 0", hold, bus.btn_level);
        end
        tick(5);
        // FSM sees the release at edge c1+3; repeats landing after c1+2 are suppressed
        exp_q.push_back(c0 + 6);
        for (int t = c0 + 16; t <= c1 + 2; t += 5) exp_q.push_back(t);
        n_vec++;
        if (pulses.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL repeat%0d_count: got %0d, expected %0d", hold, pulses.size(),
                     exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < pulses.size()) ? pulses[i] - c0 : -1;
            n_vec++;
            if (got != exp_q[i] - c0) begin
                n_err++;
                $display("FAIL repeat%0d_pulse%0d: got cycle %0d, expected %0d", hold, i, got,
                         exp_q[i] - c0);
            end
        end
        n_vec++;
        if (bus.press_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL repeat%0d_cnt: got %0d, expected 1", hold, bus.press_cnt);
        end
        bus.repeat_en = 1'b0;
    endtask

    task automatic test_repeat_en_drop();
        int c0;
        int c2;
        int got;
        apply_reset();
        bus.repeat_en = 1'b1;
        c0 = cyc_n;
        bus.btn_raw = 1'b1;
        // FSM samples repeat_en=0 on the edge where the first repeat would fire
        tick(15);
        bus.repeat_en = 1'b0;
        tick(10);
        n_vec++;
        if (pulses.size() != 1) begin
            n_err++;
            $display("FAIL en_drop_count: got %0d, expected 1", pulses.size());
        end
        c2 = cyc_n;
        bus.repeat_en = 1'b1;
        tick(12);
        got = (pulses.size() > 1) ? pulses[1] - c2 : -1;
        n_vec++;
        if (got != 10) begin
            n_err++;
            $display("FAIL en_rearm_delay: got %0d, expected 10", got);
        end
        n_vec++;
        if (pulses.size() != 2 || pulses[0] != c0 + 6) begin
            n_err++;
            $display("FAIL en_pulse_list: got %0d pulses, expected 2", pulses.size());
        end
        bus.repeat_en = 1'b0;
        bus.btn_raw   = 1'b0;
        tick(10);
    endtask

    task automatic test_release_bounce();
        int level_lo;
        apply_reset();
        bus.btn_raw = 1'b1;
        tick(10);
        pulses.delete();
        level_lo = 0;
        bus.btn_raw = 1'b0;
        tick(1);
        if (!bus.btn_level) level_lo++;
        tick(1);
        if (!bus.btn_level) level_lo++;
        bus.btn_raw = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (!bus.btn_level) level_lo++;
        end
        n_vec++;
        if (pulses.size() != 0) begin
            n_err++;
            $display("FAIL relb_pulses: got %0d, expected 0", pulses.size());
        end
        n_vec++;
        if (level_lo != 0) begin
            n_err++;
            $display("FAIL relb_level: got %0d low cycles, expected 0", level_lo);
        end
        n_vec++;
        if (bus.press_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL relb_cnt: got %0d, expected 1", bus.press_cnt);
        end
        bus.btn_raw = 1'b0;
        tick(10);
    endtask

    task automatic test_wrap();
        apply_reset();
        repeat (256) press();
        n_vec++;
        if (bus.press_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_256: got %0d, expected 0", bus.press_cnt);
        end
        n_vec++;
        if (pulses.size() != 256) begin
            n_err++;
            $display("FAIL wrap_pulses: got %0d, expected 256", pulses.size());
        end
        press();
        n_vec++;
        if (bus.press_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL wrap_257: got %0d, expected 1", bus.press_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        int got;
        // Mid-REPEAT
        apply_reset();
        bus.repeat_en = 1'b1;
        bus.btn_raw   = 1'b1;
        tick(18);
        n_vec++;
        if (bus.btn_level !== 1'b1 || bus.press_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL rmid_pre_state: got level %b cnt %0d, expected 1 1", bus.btn_level,
                     bus.press_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.btn_pulse, bus.btn_level, bus.press_cnt} !== 10'd0) begin
            n_err++;
            $display("FAIL rmid_repeat_outs: got p%b l%b c%0d, expected all 0", bus.btn_pulse,
                     bus.btn_level, bus.press_cnt);
        end
        // Release reset with the button still held
        bus.repeat_en = 1'b0;
        tick(2);
        pulses.delete();
        c0 = cyc_n;
        rst_n = 1'b1;
        tick(20);
        n_vec++;
        if (pulses.size() != 1) begin
            n_err++;
            $display("FAIL rmid_held_count: got %0d, expected 1", pulses.size());
        end
        got = (pulses.size() > 0) ? pulses[0] - c0 : -1;
        n_vec++;
        if (got != 6) begin
            n_err++;
            $display("FAIL rmid_held_latency: got %0d, expected 6", got);
        end
        n_vec++;
        if (bus.press_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL rmid_held_cnt: got %0d, expected 1", bus.press_cnt);
        end
        // Mid-PRESS_DB with a nonzero count
        bus.btn_raw = 1'b0;
        tick(10);
        bus.btn_raw = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.btn_pulse, bus.btn_level, bus.press_cnt} !== 10'd0) begin
            n_err++;
            $display("FAIL rmid_pressdb_outs: got p%b l%b c%0d, expected all 0", bus.btn_pulse,
                     bus.btn_level, bus.press_cnt);
        end
        bus.btn_raw = 1'b0;
        tick(2);
    endtask

    task automatic test_integration();
        logic [7:0] exp_led;
        int bad_onehot;
        apply_reset();
        bad_onehot = 0;
        for (int k = 1; k <= 8; k++) begin
            bus.btn_raw = 1'b1;
            for (int i = 0; i < 16; i++) begin
                if (i == 8) bus.btn_raw = 1'b0;
                tick(1);
                if (!$onehot(led)) bad_onehot++;
            end
            exp_led = 8'h01 << (k % 8);
            n_vec++;
            if (led !== exp_led) begin
                n_err++;
                $display("FAIL integ_led_press%0d: got %b, expected %b", k, led, exp_led);
            end
        end
        n_vec++;
        if (bad_onehot != 0) begin
            n_err++;
            $display("FAIL integ_onehot: got %0d bad cycles, expected 0", bad_onehot);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat(46);
        test_repeat(18);
        test_repeat_en_drop();
        test_release_bounce();
        test_wrap();
        test_reset_mid();
        test_integration();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
